priority_arbiter_n: RTL and testbench

//  Parametrised successor to the 4-input priority encoder: N-request arbiter with

---
 rtl/prio_arb_pkg.sv | 16 +
 rtl/prio_find.sv | 25 ++
 rtl/priority_arbiter_n.sv | 144 ++++++++++++++
 tb/tb_priority_arbiter_n.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared constants and state encoding for the N-input priority arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package prio_arb_pkg;

    // Arbitration policy selected by the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // ST_GRANT encodes as 1 so the state bit doubles as gnt_valid
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_find.sv
// Highest-set-bit finder: reports whether any bit is set and the index of the top one.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input vector.
module prio_find #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan upward so the last (highest) set bit overwrites lower ones
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (vec[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_n.sv
// N-request arbiter, fixed (MSB highest) or round-robin priority, registered grant.
// Latency: 1 clk from req to gnt_valid; back-to-back grants one per clk.
// Backpressure: grant held stable while gnt_ready is low; re-arbitrates only on handshake.
module priority_arbiter_n
    import prio_arb_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot
);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_dec;
    logic [IDX_W-1:0] ptr_eff;
    logic             handshake;
    logic [N-1:0]     mask_le_ptr;
    logic [N-1:0]     req_masked;
    logic             msk_found;
    logic [IDX_W-1:0] msk_idx;
    logic             all_found;
    logic [IDX_W-1:0] all_idx;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;
    logic             gnt_load;
    logic             gnt_drop;
    logic             ptr_load;

    assign handshake = (state == ST_GRANT) && gnt_ready;
    assign gnt_valid = (state == ST_GRANT);

    // Pointer moves just below the granted index; 0 wraps to the top requester
    always_comb begin
        ptr_dec = gnt_idx - 1'b1;
        if (gnt_idx == '0) begin
            ptr_dec = IDX_W'(N - 1);
        end
    end

    // A handshake re-arbitrates in the same cycle, so the mask must use the updated pointer
    always_comb begin
        ptr_eff = ptr;
        if (handshake) begin
            ptr_eff = ptr_dec;
        end
    end

    // Requesters at or below the pointer form the round-robin candidate set
    always_comb begin
        mask_le_ptr = '0;
        for (int k = 0; k < N; k++) begin
            mask_le_ptr[k] = (k <= int'(ptr_eff));
        end
    end

    assign req_masked = req & mask_le_ptr;

    prio_find #(.N(N)) u_find_masked (
        .vec   (req_masked),
        .found (msk_found),
        .idx   (msk_idx)
    );

    prio_find #(.N(N)) u_find_all (
        .vec   (req),
        .found (all_found),
        .idx   (all_idx)
    );

    // Round-robin takes the masked winner if any, otherwise wraps to the overall winner
    always_comb begin
        win_idx = all_idx;
        if ((mode == MODE_RR) && msk_found) begin
            win_idx = msk_idx;
        end
    end

    // One-hot decode of the winner, loaded alongside the binary index
    always_comb begin
        win_onehot = '0;
        for (int k = 0; k < N; k++) begin
            win_onehot[k] = (int'(win_idx) == k);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter GRANT on any request, leave only on a handshake with nothing pending
    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE) begin
            if (all_found) begin
                state_nxt = ST_GRANT;
            end
        end else begin
            if (gnt_ready && !all_found) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Control outputs: when to load a new grant, drop the one-hot, and advance the pointer
    always_comb begin
        gnt_load = ((state == ST_IDLE) || handshake) && all_found;
        gnt_drop = handshake && !all_found;
        ptr_load = handshake;
    end

    // Grant and pointer registers; gnt_idx deliberately keeps its value when the grant drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            ptr        <= IDX_W'(N - 1);
        end else begin
            if (ptr_load) begin
                ptr <= ptr_dec;
            end
            if (gnt_load) begin
                gnt_idx    <= win_idx;
                gnt_onehot <= win_onehot;
            end else if (gnt_drop) begin
                gnt_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Bench for priority_arbiter_n (N=8): directed scenarios followed by random traffic.
// Expected grants come from a small reference model built on the arbitration rules.
// All checks are sampled 1 ns after the rising edge; inputs change at the same point.
module tb_priority_arbiter_n;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mode;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    priority_arbiter_n #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    always #5 clk = ~clk;

    // winner by rule: RR looks from ptr downward first, then everything from the top
    function automatic int pick(input logic [7:0] r, input logic m, input int p);
        if (m) begin
            for (int k = p; k >= 0; k--) if (r[k]) return k;
        end
        for (int k = 7; k >= 0; k--) if (r[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = N - 1;
    endtask

    // advance the model using the current inputs, then clock the DUT
    task automatic cyc();
        if (!m_valid) begin
            if (req != 8'h00) begin
                m_valid = 1'b1;
                m_idx   = pick(req, mode, m_ptr);
            end
        end else if (gnt_ready) begin
            m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
            if (req != 8'h00) m_idx = pick(req, mode, m_ptr);
            else              m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag);
        logic [7:0] exp_oh;
        logic [7:0] one;
        one    = 8'h01;
        exp_oh = m_valid ? (one << m_idx) : 8'h00;
        checks++;
        assert (gnt_valid === m_valid) else begin
            errors++;
            $error("FAIL %s valid: got %b want %b", tag, gnt_valid, m_valid);
        end
        checks++;
        assert (gnt_idx === 3'(m_idx)) else begin
            errors++;
            $error("FAIL %s idx: got %0d want %0d", tag, gnt_idx, m_idx);
        end
        checks++;
        assert (gnt_onehot === exp_oh) else begin
            errors++;
            $error("FAIL %s onehot: got %h want %h", tag, gnt_onehot, exp_oh);
        end
    endtask

    // directed expectation written straight from the scenario description
    task automatic expect_out(input string tag, input logic v, input logic [2:0] i,
                              input logic [7:0] oh);
        checks++;
        assert (gnt_valid === v && gnt_idx === i && gnt_onehot === oh) else begin
            errors++;
            $error("FAIL %s: got v=%b idx=%0d oh=%h want v=%b idx=%0d oh=%h",
                   tag, gnt_valid, gnt_idx, gnt_onehot, v, i, oh);
        end
    endtask

    // async reset mid-cycle; outputs must clear before any clock edge
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        expect_out(tag, 1'b0, 3'd0, 8'h00);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] rr_seq [9];
        rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

        rst_n     = 1'b0;
        req       = 8'h00;
        mode      = 1'b0;
        gnt_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset("reset_init");
        cyc();
        chk("idle_after_reset");

        // 1: fixed priority, held under backpressure and after req drops
        mode = 1'b0; req = 8'b0010_0110; gnt_ready = 1'b0;
        cyc(); chk("fix_first"); expect_out("fix_first_c", 1'b1, 3'd5, 8'h20);
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_out("fix_hold", 1'b1, 3'd5, 8'h20);
        end
        req = 8'h00;
        cyc(); chk("fix_drop_req"); expect_out("fix_drop_req_c", 1'b1, 3'd5, 8'h20);
        gnt_ready = 1'b1;
        cyc(); chk("fix_release"); expect_out("fix_release_c", 1'b0, 3'd5, 8'h00);

        // 2: round-robin sweep from a fresh reset
        gnt_ready = 1'b0;
        apply_reset("reset_pre_rr");
        mode = 1'b1; req = 8'hFF; gnt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] oh;
            oh = 8'h01 << rr_seq[i];
            cyc(); chk("rr_sweep"); expect_out("rr_sweep_c", 1'b1, rr_seq[i], oh);
        end

        // 3: wrap when nothing at or below the pointer is requesting
        cyc(); expect_out("rr_to6", 1'b1, 3'd6, 8'h40);
        cyc(); expect_out("rr_to5", 1'b1, 3'd5, 8'h20);
        req = 8'b1100_0000;
        cyc(); chk("rr_wrap"); expect_out("rr_wrap_c", 1'b1, 3'd7, 8'h80);
        cyc(); chk("rr_after_wrap"); expect_out("rr_after_wrap_c", 1'b1, 3'd6, 8'h40);
        req = 8'h00;
        cyc(); expect_out("rr_idle", 1'b0, 3'd6, 8'h00);

        // 4: single-cycle pulse on requester 0
        gnt_ready = 1'b0; req = 8'h01;
        cyc(); chk("pulse_grant"); expect_out("pulse_grant_c", 1'b1, 3'd0, 8'h01);
        req = 8'h00;
        cyc(); cyc(); expect_out("pulse_hold", 1'b1, 3'd0, 8'h01);
        gnt_ready = 1'b1;
        cyc(); chk("pulse_done"); expect_out("pulse_done_c", 1'b0, 3'd0, 8'h00);

        // 5: mode sampled at the arbitration edge
        gnt_ready = 1'b0; req = 8'h80; mode = 1'b1;
        cyc(); expect_out("ms_setup", 1'b1, 3'd7, 8'h80);
        req = 8'h81; gnt_ready = 1'b1;
        cyc(); chk("ms_rr"); expect_out("ms_rr_c", 1'b1, 3'd0, 8'h01);
        req = 8'h80;
        cyc(); expect_out("ms_setup2", 1'b1, 3'd7, 8'h80);
        req = 8'h81; mode = 1'b0;
        cyc(); chk("ms_fixed"); expect_out("ms_fixed_c", 1'b1, 3'd7, 8'h80);

        // 6: reset during a held grant, then first RR grant
        gnt_ready = 1'b0;
        cyc(); expect_out("rst_pre", 1'b1, 3'd7, 8'h80);
        mode = 1'b1; req = 8'hFF;
        apply_reset("reset_mid_grant");
        cyc(); chk("rst_first"); expect_out("rst_first_c", 1'b1, 3'd7, 8'h80);

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            req       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            mode      = 1'($urandom_range(0, 1));
            gnt_ready = ($urandom_range(0, 2) != 0);
            cyc();
            chk("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
